romulusn_round_ctrl: RTL
========================

Name: romulusn_round_ctrl

Overview:
- Control FSM for the Romulus-N SKINNY-128-384+ datapath.
- Each block goes through four phases in order: load the 128-bit state over 32-bit words; optionally load nonce/key (TK1/TK2); run 40 rounds at 8 rounds per cycle; unload the 128-bit state over 32-bit words.
- Drives every enable, shift, reset, domain and round-constant input of the datapath top level.
- Talks to the external mode logic through a start/done command port and valid/ready word handshakes.

Parameters:
- ROUNDS_PER_CYC, 8, unrolled rounds per RUN cycle (fixed; datapath is 8-way unrolled)
- NUM_RUN, 5, RUN cycles per block (40 rounds)
- WORDS, 4, 32-bit beats per 128-bit load or unload

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  command strobe, accepted only in IDLE
- cmd_dom  in  8  domain byte, latched at start
- cmd_dec  in  1  decrypt block, latched at start
- cmd_ldn  in  1  load nonce/key phase, latched at start
- cmd_cnt  in  1  increment block counter after RUN, latched at start
- cmd_ad  in  1  counter permutation select (AD vs message), latched at start
- cmd_init  in  1  clear counter/state registers at start, latched at start
- in_valid  in  1  pdi/sdi word valid
- in_ready  out  1  word accepted when in_valid & in_ready
- out_valid  out  1  pdo word valid
- out_ready  in  1  pdo word consumed
- busy  out  1  high whenever not IDLE
- done  out  1  one-cycle pulse on the OUT→IDLE transition
- srst, senc, sse  out  1 each  state register controls
- xrst, xenc, xse  out  1 each  TK2 register controls
- yrst, yenc, yse  out  1 each  TK1 register controls
- zrst, zenc, zse  out  1 each  TK3/counter register controls
- erst  out  1  auxiliary register reset
- correct_cnt  out  1  select current counter as LFSR input
- tk1s  out  1  counter permutation select
- domain  out  8  registered cmd_dom
- decrypt  out  4  per-word decrypt mask
- constant, constant2 … constant8  out  6 each  round constants for unrolled rounds 0..7 of the current RUN cycle

Behaviour:
- Clocking and reset
  - Single clock clk.
  - rst is synchronous active-high and has priority over everything.
  - On rst: FSM to IDLE; all 1-bit outputs 0; domain=0, decrypt=0, all constants=0; beat counter=0, run counter=0; RC LFSR=6'h00.
  - rst in any phase aborts the block with no done pulse.
- IDLE
  - in_ready=0, out_valid=0.
  - start latches all cmd_* fields and sets RC=6'h00.
  - If cmd_init=1: pulse srst, xrst, yrst, zrst and erst for exactly the cycle after start.
  - Next state is LOADS.
- LOADS (4 beats)
  - in_ready=1.
  - sse = in_valid & in_ready.
  - The beat counter increments on each accepted word.
  - After beat 3: go to LOADN if ldn=1, otherwise RUN.
  - No-valid cycles are stalls: all shift enables stay 0.
- LOADN (4 beats)
  - in_ready=1.
  - yse = xse = accepted (pdi carries the nonce, sdi carries the key, in the same beat).
  - After beat 3, go to RUN.
- RUN (exactly 5 cycles, no stalls)
  - in_ready=0.
  - senc = xenc = yenc = zenc = 1.
  - constant..constant8 are combinational from the RC LFSR advanced 1..8 steps. LFSR step: rc ← {rc[4:0], rc[5]^rc[4]^1'b1}.
  - RC register advances 8 steps per RUN cycle.
  - Constant sequence from 6'h00 starts 01,03,07,0F,1F,3E,3D,3B, continues 37,2F,…, and round 40 is 1A.
  - After run counter 4: go to CNT if cnt=1, otherwise OUT.
- CNT (1 cycle)
  - zenc=1, correct_cnt=1, tk1s=ad, all other enables 0.
  - Next state is OUT.
- OUT (4 beats)
  - out_valid=1.
  - sse = out_valid & out_ready.
  - decrypt = {4{dec}} while in OUT, 0 otherwise.
  - After beat 3 is consumed: done=1 and go to IDLE.
- Outputs held outside their phase
  - Constants are 0 outside RUN.
  - tk1s is 0 outside CNT.
  - domain holds its latched value until the next start.
- Simultaneous events
  - start while busy is ignored.
  - start and rst in the same cycle: rst wins.
- Invariants
  - At most one of {se, enc} is high per register per cycle.
  - No beat is lost or duplicated under arbitrary valid/ready patterns.

Test Plan:
- Reset then start with init=1, ldn=0, cnt=0, dom=8'h08 → all five rst outputs high for 1 cycle; 4 sse beats; senc high for 5 cycles; 4 out beats; done 1 cycle; domain=8'h08.
- RUN constants check → cycle 0 gives constant=01, constant8=3B; cycle 1 gives 37,2F,1E,3C,39,33,27,0E; cycle 4 gives constant8=1A.
- ldn=1 with in_valid toggling 1,0,1,0… → exactly 4 sse beats then exactly 4 beats with xse and yse both high; no shift enable on any invalid cycle.
- cnt=1, ad=1, dec=1 → CNT cycle shows zenc=1, correct_cnt=1, tk1s=1; decrypt=4'hF for all OUT beats; out_ready held low 3 cycles → sse stays 0 and out_valid stays 1.
- rst asserted in RUN cycle 2 → next cycle IDLE, all outputs 0, no done; a fresh start then completes normally with RC restarting at 01.
- start pulsed during LOADS and OUT → ignored; cmd_dom change during the block → domain unchanged.

Source files
------------

// File: rtl/romulusn_round_ctrl.sv
// Control FSM for the Romulus-N SKINNY-128-384+ datapath: it sequences the load of the
// state and optional nonce/key, 40 rounds run 8 per cycle, then the unload of the state.
// Word handshakes: a word moves in a cycle only when in_valid & in_ready (input) or
// out_valid & out_ready (output). in_ready and out_valid depend only on FSM state.
module romulusn_round_ctrl #(
  parameter int ROUNDS_PER_CYC = 8,
  parameter int NUM_RUN        = 5,
  parameter int WORDS          = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] cmd_dom,
  input  logic       cmd_dec,
  input  logic       cmd_ldn,
  input  logic       cmd_cnt,
  input  logic       cmd_ad,
  input  logic       cmd_init,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic       srst,
  output logic       senc,
  output logic       sse,
  output logic       xrst,
  output logic       xenc,
  output logic       xse,
  output logic       yrst,
  output logic       yenc,
  output logic       yse,
  output logic       zrst,
  output logic       zenc,
  output logic       zse,
  output logic       erst,
  output logic       correct_cnt,
  output logic       tk1s,
  output logic [7:0] domain,
  output logic [3:0] decrypt,
  output logic [5:0] constant,
  output logic [5:0] constant2,
  output logic [5:0] constant3,
  output logic [5:0] constant4,
  output logic [5:0] constant5,
  output logic [5:0] constant6,
  output logic [5:0] constant7,
  output logic [5:0] constant8,
  output logic [2:0] dbg_state
);

  localparam int BW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int RW = (NUM_RUN > 1) ? $clog2(NUM_RUN) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(WORDS - 1);
  localparam logic [RW-1:0] RUN_LAST  = RW'(NUM_RUN - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOADS = 3'd1,
    ST_LOADN = 3'd2,
    ST_RUN   = 3'd3,
    ST_CNT   = 3'd4,
    ST_OUT   = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [BW-1:0]   r_beat;
  logic [RW-1:0]   r_run;
  logic [5:0]      r_rc;
  logic [7:0]      r_dom;
  logic            r_dec;
  logic            r_ldn;
  logic            r_cnt;
  logic            r_ad;
  logic            r_init_pulse;

  logic            w_start_acc;
  logic            w_in_acc;
  logic            w_out_acc;
  logic            w_beat_last;
  logic            w_run_last;
  logic [5:0]      w_rc [0:ROUNDS_PER_CYC];

  assign w_start_acc = start && (r_state == ST_IDLE);
  assign w_in_acc    = in_valid && ((r_state == ST_LOADS) || (r_state == ST_LOADN));
  assign w_out_acc   = out_ready && (r_state == ST_OUT);
  assign w_beat_last = (r_beat == BEAT_LAST);
  assign w_run_last  = (r_run == RUN_LAST);
  assign dbg_state   = r_state;
  assign domain      = r_dom;

  // Round-constant LFSR unrolled: w_rc[k] is the register advanced k steps.
  always_comb begin
    w_rc[0] = r_rc;
    for (int k = 1; k <= ROUNDS_PER_CYC; k++) begin
      w_rc[k] = {w_rc[k-1][4:0], w_rc[k-1][5] ^ w_rc[k-1][4] ^ 1'b1};
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_LOADS;
      ST_LOADS: if (w_in_acc && w_beat_last) w_next = r_ldn ? ST_LOADN : ST_RUN;
      ST_LOADN: if (w_in_acc && w_beat_last) w_next = ST_RUN;
      ST_RUN:   if (w_run_last) w_next = r_cnt ? ST_CNT : ST_OUT;
      ST_CNT:   w_next = ST_OUT;
      ST_OUT:   if (w_out_acc && w_beat_last) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = (r_state != ST_IDLE);
    done        = 1'b0;
    sse         = 1'b0;
    senc        = 1'b0;
    xse         = 1'b0;
    xenc        = 1'b0;
    yse         = 1'b0;
    yenc        = 1'b0;
    zse         = 1'b0;
    zenc        = 1'b0;
    correct_cnt = 1'b0;
    tk1s        = 1'b0;
    decrypt     = 4'h0;
    constant    = 6'h00;
    constant2   = 6'h00;
    constant3   = 6'h00;
    constant4   = 6'h00;
    constant5   = 6'h00;
    constant6   = 6'h00;
    constant7   = 6'h00;
    constant8   = 6'h00;
    srst        = r_init_pulse;
    xrst        = r_init_pulse;
    yrst        = r_init_pulse;
    zrst        = r_init_pulse;
    erst        = r_init_pulse;
    case (r_state)
      ST_LOADS: begin
        in_ready = 1'b1;
        sse      = w_in_acc;
      end
      ST_LOADN: begin
        in_ready = 1'b1;
        xse      = w_in_acc;
        yse      = w_in_acc;
      end
      ST_RUN: begin
        senc      = 1'b1;
        xenc      = 1'b1;
        yenc      = 1'b1;
        zenc      = 1'b1;
        constant  = w_rc[1];
        constant2 = w_rc[2];
        constant3 = w_rc[3];
        constant4 = w_rc[4];
        constant5 = w_rc[5];
        constant6 = w_rc[6];
        constant7 = w_rc[7];
        constant8 = w_rc[8];
      end
      ST_CNT: begin
        zenc        = 1'b1;
        correct_cnt = 1'b1;
        tk1s        = r_ad;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        sse       = w_out_acc;
        decrypt   = {4{r_dec}};
        done      = w_out_acc && w_beat_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_beat       <= '0;
      r_run        <= '0;
      r_rc         <= 6'h00;
      r_dom        <= 8'h00;
      r_dec        <= 1'b0;
      r_ldn        <= 1'b0;
      r_cnt        <= 1'b0;
      r_ad         <= 1'b0;
      r_init_pulse <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_init_pulse <= w_start_acc && cmd_init;
      if (w_start_acc) begin
        r_dom  <= cmd_dom;
        r_dec  <= cmd_dec;
        r_ldn  <= cmd_ldn;
        r_cnt  <= cmd_cnt;
        r_ad   <= cmd_ad;
        r_rc   <= 6'h00;
        r_beat <= '0;
        r_run  <= '0;
      end
      // One beat counter serves all three word phases; it is back at 0 after each.
      if (w_in_acc || w_out_acc) begin
        r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
      end
      if (r_state == ST_RUN) begin
        r_rc  <= w_rc[ROUNDS_PER_CYC];
        r_run <= w_run_last ? '0 : r_run + 1'b1;
      end
    end
  end

endmodule
